// File: rtl/systolic_pkg.sv
// Types and constants shared by the systolic array, its feeder and the benches.
package systolic_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feed_state_t;

endpackage

// File: rtl/feeder_buf.sv
// One channel buffer: single write port, single combinational read port.
// A read of the address being written returns the new data, so a frame started
// in the same cycle as a write already sees the written sample.
module feeder_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

endmodule

// File: rtl/systolic_feeder.sv
// Streams two channel buffers into the systolic array, channel 2 lagging by SKEW.
//   state  | meaning
//   IDLE   | outputs zero, buffers writable, waiting for start
//   STREAM | presenting sample index cnt on the outputs
//   DONE   | one-cycle done pulse, outputs zero
module systolic_feeder #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int SKEW   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_ch,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    output logic                       done,
    output logic                       x_valid,
    output logic [DATA_W-1:0]          x01,
    output logic [DATA_W-1:0]          x02
);
    import systolic_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(2 * DEPTH) + 1;

    feed_state_t       state;
    logic [CW-1:0]     cnt;
    logic [LW-1:0]     l_q;
    logic [LW-1:0]     len_clamp;
    logic [LW-1:0]     l_eff;
    logic [CW-1:0]     n_idx;
    logic [CW-1:0]     d_idx;
    logic [CW-1:0]     last_idx;
    logic              in1;
    logic              in2;
    logic              we;
    logic [AW-1:0]     rd1;
    logic [AW-1:0]     rd2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    assign we = wr_en && (state == IDLE);

    feeder_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf1 (
        .clk     (clk),
        .wr_en   (we && !wr_ch),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd1),
        .rd_data (rd_data1)
    );

    feeder_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf2 (
        .clk     (clk),
        .wr_en   (we && wr_ch),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd2),
        .rd_data (rd_data2)
    );

    // Outputs are registered, so the index evaluated here is the one shown next cycle.
    always_comb begin
        len_clamp = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
        l_eff     = (state == IDLE) ? len_clamp : l_q;
        n_idx     = (state == IDLE) ? '0 : cnt + CW'(1);
        last_idx  = CW'(l_q) + CW'(SKEW) - CW'(1);
        in1       = n_idx < CW'(l_eff);
        in2       = (n_idx >= CW'(SKEW)) && (n_idx < CW'(l_eff) + CW'(SKEW));
        rd1       = '0;
        rd2       = '0;
        d_idx     = '0;
        if (in1) begin
            rd1 = n_idx[AW-1:0];
        end
        if (in2) begin
            d_idx = n_idx - CW'(SKEW);
            rd2   = d_idx[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            l_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            x_valid <= 1'b0;
            x01     <= '0;
            x02     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        l_q <= len_clamp;
                        cnt <= '0;
                        if (len_clamp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= STREAM;
                            busy    <= 1'b1;
                            x_valid <= in1 || in2;
                            x01     <= in1 ? rd_data1 : '0;
                            x02     <= in2 ? rd_data2 : '0;
                        end
                    end
                end
                STREAM: begin
                    if (cnt == last_idx) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        x_valid <= 1'b0;
                        x01     <= '0;
                        x02     <= '0;
                    end else begin
                        cnt     <= n_idx;
                        x_valid <= in1 || in2;
                        x01     <= in1 ? rd_data1 : '0;
                        x02     <= in2 ? rd_data2 : '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: per-cycle expected outputs queued at start, popped each cycle.
module tb_systolic_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SKEW  = 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          wr_ch;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [3:0]    len;
    logic          busy;
    logic          done;
    logic          x_valid;
    logic [DW-1:0] x01;
    logic [DW-1:0] x02;

    systolic_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .SKEW(SKEW)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .x_valid (x_valid),
        .x01     (x01),
        .x02     (x02)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          bsy;
        logic          dn;
    } exp_t;

    typedef struct packed {
        logic [4:0] len_in;
        logic [4:0] done_off;
    } vec_t;

    exp_t          sb[$];
    logic [DW-1:0] m1 [DEPTH];
    logic [DW-1:0] m2 [DEPTH];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input int k, input exp_t got, input exp_t e);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s cycle t+%0d: got v=%0b x01=%h x02=%h busy=%0b done=%0b, want v=%0b x01=%h x02=%h busy=%0b done=%0b",
                     name, k, got.v, got.a, got.b, got.bsy, got.dn, e.v, e.a, e.b, e.bsy, e.dn);
        end
    endtask

    task automatic push_model(input int len_in);
        int L;
        exp_t e;
        L = (len_in > DEPTH) ? DEPTH : len_in;
        if (L > 0) begin
            for (int i = 0; i < L + SKEW; i++) begin
                e     = '0;
                e.bsy = 1'b1;
                if (i < L) e.a = m1[i];
                if (i >= SKEW && i < L + SKEW) e.b = m2[i - SKEW];
                e.v   = (i < L) || (i >= SKEW && i < L + SKEW);
                sb.push_back(e);
            end
        end
        e    = '0;
        e.dn = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wr(input logic ch, input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_addr = 3'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        if (ch) m2[addr] = data; else m1[addr] = data;
    endtask

    // inj_k: drive a dropped write of 0xDEAD to buf1[0] plus a start pulse at cycle t+inj_k.
    // rst_k: assert rst at cycle t+rst_k. same_wr: write buf1[0]=0x77 in the start cycle.
    task automatic run_frame(input string name, input int len_in, input int done_off,
                             input int inj_k, input int rst_k, input bit same_wr);
        exp_t got;
        exp_t e;
        int   seen_done;
        int   k;
        @(negedge clk);
        start = 1'b1;
        len   = 4'(len_in);
        if (same_wr) begin
            wr_en   = 1'b1;
            wr_ch   = 1'b0;
            wr_addr = 3'd0;
            wr_data = 32'h77;
            m1[0]   = 32'h77;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        push_model(len_in);
        seen_done = -1;
        k = 0;
        while (sb.size() > 0 && k < 40) begin
            k++;
            @(negedge clk);
            wr_en = 1'b0;
            start = 1'b0;
            rst   = 1'b0;
            e   = sb.pop_front();
            got = '{v: x_valid, a: x01, b: x02, bsy: busy, dn: done};
            check(name, k, got, e);
            if (done && seen_done < 0) seen_done = k;
            if (k == inj_k) begin
                wr_en   = 1'b1;
                wr_ch   = 1'b0;
                wr_addr = 3'd0;
                wr_data = 32'hDEAD;
                start   = 1'b1;
            end
            if (k == rst_k) begin
                rst = 1'b1;
                sb.delete();
                repeat (3) sb.push_back('0);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d expected cycles left, want 0", name, sb.size());
            sb.delete();
        end
        if (rst_k == 0) begin
            n_checks++;
            if (seen_done != done_off) begin
                n_fail++;
                $display("FAIL %s done offset: got t+%0d, want t+%0d", name, seen_done, done_off);
            end
        end
    endtask

    vec_t tbl [6];

    initial begin
        exp_t got;
        tbl[0] = '{len_in: 5'd6,  done_off: 5'd8};
        tbl[1] = '{len_in: 5'd0,  done_off: 5'd1};
        tbl[2] = '{len_in: 5'd15, done_off: 5'd10};
        tbl[3] = '{len_in: 5'd1,  done_off: 5'd3};
        tbl[4] = '{len_in: 5'd8,  done_off: 5'd10};
        tbl[5] = '{len_in: 5'd3,  done_off: 5'd5};

        rst = 1'b1; wr_en = 1'b0; wr_ch = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = '{v: x_valid, a: x01, b: x02, bsy: busy, dn: done};
            check("reset_idle", i, got, '0);
        end

        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, 32'(i + 1));
            wr(1'b1, i, 32'(32'h11 + i));
        end

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("tbl_len%0d", int'(tbl[i].len_in)), int'(tbl[i].len_in),
                      int'(tbl[i].done_off), 0, 0, 1'b0);
        end

        run_frame("protect", 6, 8, 2, 0, 1'b0);
        run_frame("after_protect", 6, 8, 0, 0, 1'b0);
        run_frame("rst_mid", 6, 0, 0, 3, 1'b0);
        run_frame("replay", 6, 8, 0, 0, 1'b0);
        run_frame("wr_with_start", 2, 4, 0, 0, 1'b1);
        run_frame("back_to_back", 2, 4, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
